// File: rtl/display_scheduler_pkg.sv
// Shared types and sizing helpers for the display scheduler.
// Combinational only: no latency or backpressure.
package display_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DWELL = 2'd2
    } state_e;

    // Counter sizing: the result is always at least 1 bit wide.
    function automatic int clog2(input longint v);
        int     r;
        longint x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    localparam int DEF_NUM_REQ     = 4;
    localparam int DEF_DATA_WIDTH  = 24;
    localparam int DEF_LOAD_HOLD   = 'h10000;
    localparam int DEF_DWELL       = 50000000;
    localparam int DEF_OWNER_W     = clog2(DEF_NUM_REQ);
    localparam int DEF_LOAD_CNT_W  = clog2(DEF_LOAD_HOLD);
    localparam int DEF_DWELL_CNT_W = clog2(DEF_DWELL);

endpackage

// File: rtl/display_scheduler_if.sv
// Requester-to-display scheduler signal bundle; master = requesters, slave = scheduler.
// Level-based requests, no backpressure: a requester simply waits for its grant.
interface display_scheduler_if
    import display_sched_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int OWNER_W    = clog2(NUM_REQ)
);

    logic [NUM_REQ-1:0]            i_REQ;
    logic [NUM_REQ*DATA_WIDTH-1:0] i_DATA;
    logic [NUM_REQ-1:0]            o_GNT;
    logic [OWNER_W-1:0]            o_OWNER;
    logic [DATA_WIDTH-1:0]         o_BUS;
    logic                          o_READ_BUS;
    logic                          o_CLEAR_n;

    modport master (
        output i_REQ, i_DATA,
        input  o_GNT, o_OWNER, o_BUS, o_READ_BUS, o_CLEAR_n
    );

    modport slave (
        input  i_REQ, i_DATA,
        output o_GNT, o_OWNER, o_BUS, o_READ_BUS, o_CLEAR_n
    );

endinterface

// File: rtl/display_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after last_i+1, with wrap.
// Zero latency; no backpressure, vld_o low when nothing requests.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          vld_o
);

    int cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        cand  = 0;
        for (int k = 0; k < N; k++) begin
            cand = (int'(last_i) + 1 + k) % N;
            if (!vld_o && req_i[cand]) begin
                vld_o       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/display_scheduler.sv
// Time-shares the seven-segment display between requesters: round-robin grant, stretched load, minimum dwell.
// Latency: grant and load 1 cycle after request; no backpressure, other requesters wait for dwell expiry.
module display_scheduler
    import display_sched_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LOAD_HOLD  = DEF_LOAD_HOLD,
    parameter int DWELL      = DEF_DWELL
) (
    input  logic                i_SYS_CLOCK,
    input  logic                i_RESET,
    display_scheduler_if.slave  sched_if
);

    localparam int OW  = clog2(NUM_REQ);
    localparam int LCW = clog2(LOAD_HOLD);
    localparam int DCW = clog2(DWELL);

    state_e                state_q, state_d;
    logic [NUM_REQ-1:0]    gnt_q, gnt_d;
    logic [OW-1:0]         owner_q, owner_d;
    logic [DATA_WIDTH-1:0] bus_q, bus_d;
    logic                  rd_q, rd_d;
    logic                  clr_n_q;
    logic [LCW-1:0]        load_cnt_q, load_cnt_d;
    logic [DCW-1:0]        dwell_cnt_q, dwell_cnt_d;

    logic [NUM_REQ-1:0]    win_gnt;
    logic [OW-1:0]         win_idx;
    logic                  win_vld;
    logic [DATA_WIDTH-1:0] win_dat;
    logic [DATA_WIDTH-1:0] own_dat;
    logic                  own_req;
    logic                  others;
    logic                  expired;
    logic                  load_done;
    logic                  upd;
    logic                  take;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (OW)
    ) u_arb (
        .req_i  (sched_if.i_REQ),
        .last_i (owner_q),
        .gnt_o  (win_gnt),
        .idx_o  (win_idx),
        .vld_o  (win_vld)
    );

    assign win_dat   = sched_if.i_DATA[win_idx*DATA_WIDTH +: DATA_WIDTH];
    assign own_dat   = sched_if.i_DATA[owner_q*DATA_WIDTH +: DATA_WIDTH];
    assign own_req   = sched_if.i_REQ[owner_q];
    assign others    = |(sched_if.i_REQ & ~gnt_q);
    assign expired   = (dwell_cnt_q == DCW'(DWELL - 1));
    assign load_done = (load_cnt_q == LCW'(LOAD_HOLD - 1));
    assign upd       = own_req && (own_dat != bus_q);
    // A new owner is taken from idle, or at dwell expiry when someone else waits.
    assign take      = ((state_q == ST_IDLE) && win_vld) ||
                       ((state_q == ST_DWELL) && !upd && expired && others);

    always_ff @(posedge i_SYS_CLOCK) begin
        if (i_RESET) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            owner_q     <= OW'(NUM_REQ - 1);
            bus_q       <= '0;
            rd_q        <= 1'b0;
            clr_n_q     <= 1'b0;
            load_cnt_q  <= '0;
            dwell_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            owner_q     <= owner_d;
            bus_q       <= bus_d;
            rd_q        <= rd_d;
            clr_n_q     <= 1'b1;
            load_cnt_q  <= load_cnt_d;
            dwell_cnt_q <= dwell_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (win_vld) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (load_done) state_d = ST_DWELL;
            end
            ST_DWELL: begin
                if (upd || (expired && others)) state_d = ST_LOAD;
                else if (expired && !own_req)    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        gnt_d       = gnt_q;
        owner_d     = owner_q;
        bus_d       = bus_q;
        rd_d        = rd_q;
        load_cnt_d  = load_cnt_q;
        dwell_cnt_d = dwell_cnt_q;

        // Dwell runs through loads and saturates so expiry stays sticky.
        if ((state_q != ST_IDLE) && !expired) dwell_cnt_d = dwell_cnt_q + DCW'(1);

        case (state_q)
            ST_LOAD: begin
                if (load_done) begin
                    rd_d       = 1'b0;
                    load_cnt_d = '0;
                end else begin
                    load_cnt_d = load_cnt_q + LCW'(1);
                end
            end
            ST_DWELL: begin
                if (upd) begin
                    bus_d      = own_dat;
                    rd_d       = 1'b1;
                    load_cnt_d = '0;
                end else if (expired && !others && !own_req) begin
                    gnt_d = '0;
                end
            end
            default: ;
        endcase

        if (take) begin
            gnt_d       = win_gnt;
            owner_d     = win_idx;
            bus_d       = win_dat;
            rd_d        = 1'b1;
            load_cnt_d  = '0;
            dwell_cnt_d = '0;
        end
    end

    assign sched_if.o_GNT      = gnt_q;
    assign sched_if.o_OWNER    = owner_q;
    assign sched_if.o_BUS      = bus_q;
    assign sched_if.o_READ_BUS = rd_q;
    assign sched_if.o_CLEAR_n  = clr_n_q;

endmodule

// File: doc/display_scheduler.md
Name: display_scheduler

Overview:
Time-shares the six-digit seven-segment display between up to NUM_REQ requesters, such as the CPU core, a debug monitor and a boot sequencer. It arbitrates round-robin and drives the display's bus, read-bus and active-low clear inputs. Each load strobe is stretched so the display, which samples on its divided clock, cannot miss it. Each owner holds the display for a minimum dwell time; the owner's value changes are forwarded while it holds the grant.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 24, display value width per requester
LOAD_HOLD, 'h10000, system-clock cycles o_READ_BUS is held high; must exceed the display divider period
DWELL, 50000000, minimum system-clock cycles an owner keeps the display, counted from its first load

Ports:
i_SYS_CLOCK  in  1  system clock
i_RESET  in  1  synchronous, active-high reset
i_REQ  in  NUM_REQ  per-requester request level
i_DATA  in  NUM_REQ*DATA_WIDTH  requester k value in bits [k*DATA_WIDTH +: DATA_WIDTH]
o_GNT  out  NUM_REQ  one-hot grant, all-zero when idle
o_OWNER  out  clog2(NUM_REQ)  index of current/last owner
o_BUS  out  DATA_WIDTH  value presented to the display bus
o_READ_BUS  out  1  display load strobe (stretched)
o_CLEAR_n  out  1  active-low display clear

Behaviour:
- Reset values (i_RESET sampled high at a clock edge): state IDLE, o_GNT=0, o_OWNER=NUM_REQ-1 so the first arbitration starts at requester 0, o_BUS=0, o_READ_BUS=0, o_CLEAR_n=0, counters=0.
- o_CLEAR_n stays 0 through reset and the first cycle after i_RESET falls, then stays 1. Reset mid-operation aborts any load or dwell immediately.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Arbitration is round-robin. Search starts at index (o_OWNER+1) mod NUM_REQ, ascending with wrap, and picks the first set i_REQ bit.
- IDLE: o_GNT=0. If any i_REQ is set, the next edge latches the winner into o_GNT/o_OWNER, latches its i_DATA into o_BUS, sets o_READ_BUS=1, clears both counters and moves to LOAD. Grant latency is 1 cycle from request.
- LOAD: o_READ_BUS=1 for exactly LOAD_HOLD cycles and o_BUS is stable. The dwell counter keeps running. On the last cycle, o_READ_BUS goes 0 and the state moves to DWELL. Owner data changes during LOAD are not loaded in this pass; they are picked up in DWELL.
- DWELL: the dwell counter increments and saturates at DWELL-1.
  - Owner still requesting and its i_DATA differs from o_BUS: re-latch o_BUS, go to LOAD. The dwell counter is not reset.
  - Dwell counter at DWELL-1 and some other requester pending: re-arbitrate in the same cycle as from IDLE. The ownership change is a single edge with no IDLE bubble.
  - Dwell counter at DWELL-1, no other requester pending, owner still requesting: stay in DWELL.
  - Dwell counter at DWELL-1, no requester pending: o_GNT=0, go to IDLE. o_BUS keeps its last value so the display keeps showing it.
- If the owner drops i_REQ before dwell expires, it keeps o_GNT and the display until expiry.
- If only the owner requests after expiry, the round-robin search wraps back to it. It is re-granted without a new load unless its data differs.
- i_DATA of non-owners is ignored. o_GNT is always one-hot or zero.
- Counter widths are clog2 of LOAD_HOLD and DWELL. The dwell counter saturates and never wraps.

Decomposition:
- Package display_sched_pkg holds the state enum (IDLE, LOAD, DWELL), a clog2 helper and the counter-width constants derived from the parameters.
- Sub-module rr_arbiter is combinational. Inputs are the request vector and the last-owner index; outputs are the one-hot winner, its index and a valid flag. It is reused elsewhere for bus arbitration.

Test Plan:
- Simulation parameters for all scenarios: NUM_REQ=3, LOAD_HOLD=4, DWELL=16.
- Reset release: hold i_RESET 3 cycles, then drop it. o_CLEAR_n=0 through reset and 1 cycle after, then 1. o_GNT=0, o_BUS=0, o_READ_BUS=0.
- Single request: i_REQ=001, data0=0x123456. Next edge gives o_GNT=001, o_BUS=0x123456, o_READ_BUS high exactly 4 cycles. Drop req; o_GNT returns to 0 exactly 16 cycles after the grant edge.
- Round-robin: i_REQ=111 constant. Grants go 001, 010, 100, 001, each held 16 cycles, with exactly one 4-cycle load per owner.
- Owner update mid-dwell: owner 0 changes data to 0x00ABCD at dwell count 8. A second 4-cycle o_READ_BUS pulse occurs with o_BUS=0x00ABCD. Release still happens at count 15.
- Late requester: owner 1 is in dwell and req2 rises at count 3. o_GNT switches to 100 exactly at count 15, never earlier. A new load follows.
- Reset mid-LOAD: assert i_RESET during the 2nd load cycle. The next edge gives o_READ_BUS=0, o_GNT=0, o_BUS=0, o_CLEAR_n=0.
